mem_bank_ctrl: RTL and testbench
================================

// Module: mem_bank_ctrl
// PURPOSE
//  Single-port word-addressed SRAM bank controller sitting directly downstream of the
//  port arbiter: consumes its mem_sel/mem_w/addr_bus/data_bus request and answers with mem_ready.
//  Models fixed access latency, returns read data on the shared tri-state data bus,
//  flags out-of-range accesses and keeps read/write transaction counters for the CNN bench.
// PARAMETERS
//  ADDR_WIDTH     16   address bus width
//  DATABUS_WIDTH  32   data word width
//  DEPTH          4096 words implemented (addresses >= DEPTH are out of range)
//  LATENCY        2    wait cycles between request capture and mem_ready (0..15)
//  CNT_WIDTH      16   width of rd_count / wr_count
// PORTS
//  clk        in     1              clock, all state on rising edge
//  rst_n      in     1              asynchronous, active-low reset
//  mem_sel    in     1              request valid
//  mem_w      in     1              1 = write, 0 = read
//  mem_ready  out    1              one-cycle completion pulse
//  addr_bus   in     ADDR_WIDTH     word address (sampled only on capture)
//  data_bus   inout  DATABUS_WIDTH  write data in / read data out (tri-state)
//  err_oob    out    1              sticky: an out-of-range access occurred
//  rd_count   out    CNT_WIDTH      completed reads, saturating
//  wr_count   out    CNT_WIDTH      completed writes, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, mem_ready=0, data_bus released ('z), err_oob=0,
//   counters=0, wait counter=0. Array contents NOT cleared. Mid-transaction reset aborts it:
//   pending write not performed, no mem_ready issued.
//  FSM: IDLE -> WAIT -> RESP -> HOLD -> IDLE.
//   IDLE: if mem_sel=1 at edge T, capture addr_bus, mem_w, data_bus (if write) into regs;
//    go WAIT with cnt=LATENCY-1 (LATENCY=0: go straight to RESP).
//   WAIT: cnt decrements each cycle; at cnt=0 go RESP. Inputs ignored.
//   RESP: mem_ready=1 for exactly this cycle (edge T+1+LATENCY). Write committed to
//    array on entry to RESP; read data registered into rdata on entry to RESP.
//   HOLD: mem_ready=0; read data still driven (arbiter samples bus the cycle after ready).
//    Always returns to IDLE next cycle.
//  data_bus driven with rdata only in RESP and HOLD of a captured read; 'z otherwise,
//   including the whole of any write transaction.
//  mem_sel held high across HOLD->IDLE is a NEW request (re-captured); earliest
//   back-to-back capture spacing is LATENCY+3 cycles.
//  Out of range (addr >= DEPTH): write dropped, read returns all-zero, err_oob set at RESP,
//   mem_ready still pulses, counters still increment.
//  Counters increment in RESP cycle by op type; saturate at all-ones, never wrap.
//  mem_sel=1 with X/Z mem_w at capture: treated as read (sim assertion flags it).
//  Only low ADDR_WIDTH bits used; index = addr, no wrap-around into the array.
// TESTING
//  1 LATENCY=2: write 0xDEADBEEF @0x0010 with sel at T -> mem_ready high only at T+3,
//    bus never driven by bank; wr_count=1.
//  2 Read @0x0010 -> mem_ready pulse at T+3, data_bus=0xDEADBEEF at T+3 and T+4, 'z at T+5;
//    rd_count=1.
//  3 mem_sel held high, reads @0x0001 continuously -> captures at T, T+5, T+10; one ready
//    pulse per capture; rd_count=3 after 3rd pulse.
//  4 Write 0x1234 @DEPTH (0x1000) then read @0x1000 -> both ready; read returns 0x0;
//    err_oob=1 and stays 1 until reset.
//  5 Write 0x5555 @0x20, drop rst_n during WAIT -> no ready, outputs reset immediately;
//    read @0x20 after release returns prior contents, not 0x5555.
//  6 Force wr_count to saturation (CNT_WIDTH=4, 17 writes) -> wr_count stays 0xF.

Source files
------------

// File: rtl/mem_bank_ctrl.sv
// Single-port word-addressed SRAM bank behind the port arbiter, with sticky OOB flag and op counters.
// Latency: mem_ready is seen LATENCY+1 cycles after the capture edge; read data stays on data_bus that cycle and the next.
// Backpressure: none. Requests are taken only in IDLE, and mem_sel is ignored for the rest of a transaction.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_sel, mem_w      request valid / write(1) read(0), sampled on capture only
//   addr_bus            word address, sampled on capture only
//   data_bus            tri-state: write data in at capture, read data out in RESP/HOLD
//   mem_ready           one-cycle completion pulse
//   err_oob             sticky out-of-range flag, cleared only by reset
//   rd_count, wr_count  saturating completed-transaction counters
module mem_bank_ctrl #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATABUS_WIDTH = 32,
    parameter int DEPTH         = 4096,
    parameter int LATENCY       = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_sel,
    input  logic                     mem_w,
    output logic                     mem_ready,
    input  logic [ADDR_WIDTH-1:0]    addr_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus,
    output logic                     err_oob,
    output logic [CNT_WIDTH-1:0]     rd_count,
    output logic [CNT_WIDTH-1:0]     wr_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // 33 bits so that a DEPTH equal to 2**32 still compares correctly
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [3:0]               wait_cnt;

    // captured request
    logic                     op_wr;
    logic [ADDR_WIDTH-1:0]    op_addr;
    logic [DATABUS_WIDTH-1:0] op_wdata;

    logic [DATABUS_WIDTH-1:0] rdata;
    logic [DATABUS_WIDTH-1:0] mem [DEPTH];

    // operands of the access that commits on this edge
    logic                     capture;
    logic                     resp_enter;
    logic                     acc_wr;
    logic [ADDR_WIDTH-1:0]    acc_addr;
    logic [DATABUS_WIDTH-1:0] acc_wdata;
    logic                     acc_in_range;
    logic [IDX_W-1:0]         acc_idx;
    logic                     bus_drive;

    assign capture = (state == ST_IDLE) && mem_sel;

    // With LATENCY=0 the commit happens on the capture edge itself,
    // so the operands must come straight from the inputs rather than
    // from the capture registers.
    always_comb begin
        acc_wr    = op_wr;
        acc_addr  = op_addr;
        acc_wdata = op_wdata;
        if (state == ST_IDLE) begin
            // An unknown mem_w falls into the else branch, so it is
            // handled as a read.
            if (mem_w) begin
                acc_wr = 1'b1;
            end else begin
                acc_wr = 1'b0;
            end
            acc_addr  = addr_bus;
            acc_wdata = data_bus;
        end
    end

    assign acc_in_range = (33'(acc_addr) < DEPTH_EXT);
    assign acc_idx      = acc_addr[IDX_W-1:0];

    assign resp_enter = ((state == ST_IDLE) && mem_sel && (LATENCY == 0)) ||
                        ((state == ST_WAIT) && (wait_cnt == 4'd0));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_sel) begin
                    state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_HOLD;
            ST_HOLD: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            op_wr    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata    <= '0;
            err_oob  <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nxt;

            if (capture) begin
                op_wr    <= acc_wr;
                op_addr  <= addr_bus;
                wait_cnt <= WAIT_INIT;
                if (acc_wr) begin
                    op_wdata <= data_bus;
                end
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (resp_enter) begin
                if (!acc_wr) begin
                    rdata <= acc_in_range ? mem[acc_idx] : '0;
                end
                if (!acc_in_range) begin
                    err_oob <= 1'b1;
                end
                // Counters stick at all-ones instead of wrapping.
                if (acc_wr) begin
                    if (wr_count != {CNT_WIDTH{1'b1}}) begin
                        wr_count <= wr_count + 1'b1;
                    end
                end else begin
                    if (rd_count != {CNT_WIDTH{1'b1}}) begin
                        rd_count <= rd_count + 1'b1;
                    end
                end
            end
        end
    end

    // The array has no reset. A reset in WAIT forces state to IDLE
    // asynchronously, so resp_enter is low and the pending write is dropped.
    always_ff @(posedge clk) begin
        if (resp_enter && acc_wr && acc_in_range) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign mem_ready = (state == ST_RESP);

    // Read data stays on the bus through HOLD because the arbiter
    // samples it the cycle after mem_ready.
    assign bus_drive = ((state == ST_RESP) || (state == ST_HOLD)) && !op_wr;
    assign data_bus  = bus_drive ? rdata : {DATABUS_WIDTH{1'bz}};

    a_mem_w_known: assert property (@(posedge clk) disable iff (!rst_n)
        ((state == ST_IDLE) && mem_sel) |-> !$isunknown(mem_w));

endmodule

// File: tb/tb_mem_bank_ctrl.sv
module tb_mem_bank_ctrl;

    localparam int LAT = 2;
    localparam logic [31:0] SENT = 32'h5A5A_A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_sel;
    logic        mem_w;
    logic        mem_ready;
    logic [15:0] addr_bus;
    wire  [31:0] data_bus;
    logic        err_oob;
    logic [3:0]  rd_count;
    logic [3:0]  wr_count;

    logic        tb_en;
    logic [31:0] tb_dat;
    assign data_bus = tb_en ? tb_dat : 32'bz;

    mem_bank_ctrl #(
        .ADDR_WIDTH(16), .DATABUS_WIDTH(32), .DEPTH(4096), .LATENCY(LAT), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_sel(mem_sel), .mem_w(mem_w),
        .mem_ready(mem_ready), .addr_bus(addr_bus), .data_bus(data_bus),
        .err_oob(err_oob), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: array contents, op totals and sticky error
    logic [31:0] model_mem [int];
    int          m_rd = 0;
    int          m_wr = 0;
    bit          m_err = 1'b0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, " rd_count"}, 32'(rd_count), 32'(sat(m_rd)));
        chk({tag, " wr_count"}, 32'(wr_count), 32'(sat(m_wr)));
        chk({tag, " err_oob"}, 32'(err_oob), 32'(m_err));
    endtask

    // Starts at a point after a negedge with the DUT in IDLE.
    // The call returns one cycle into IDLE after HOLD.
    task automatic do_txn(input string tag, input bit wr, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit noise);
        bit rd_phase;
        mem_sel  = 1'b1;
        mem_w    = wr;
        addr_bus = addr;
        tb_en    = 1'b1;
        tb_dat   = wr ? wd : SENT;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            mem_sel  = (noise && k < LAT + 3) ? 1'($urandom) : 1'b0;
            mem_w    = 1'($urandom);
            addr_bus = 16'($urandom);
            rd_phase = !wr && (k == LAT + 1 || k == LAT + 2);
            tb_en    = !rd_phase;
            tb_dat   = SENT;
            #1;
            chk($sformatf("%s ready k=%0d", tag, k), 32'(mem_ready), 32'(k == LAT + 1));
            if (rd_phase)
                chk($sformatf("%s rdata k=%0d", tag, k), data_bus, exp_rd);
            else
                chk($sformatf("%s bus released k=%0d", tag, k), data_bus, SENT);
        end
        if (wr) m_wr++; else m_rd++;
        if (addr >= 16'd4096) m_err = 1'b1;
        else if (wr) model_mem[int'(addr)] = wd;
        chk_status(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        bit          w;
        logic [31:0] d;
        logic [31:0] e;

        tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 16'h0001, 32'hCAFE0001, 32'h0};
        tbl[3] = '{1'b1, 16'h0020, 32'h11110000, 32'h0};
        tbl[4] = '{1'b1, 16'h1000, 32'h00001234, 32'h0};
        tbl[5] = '{1'b0, 16'h1000, 32'h0,        32'h0};
        tbl[6] = '{1'b1, 16'h0FFF, 32'h0BADF00D, 32'h0};
        tbl[7] = '{1'b0, 16'h0FFF, 32'h0,        32'h0BADF00D};
        tbl[8] = '{1'b0, 16'hFFFF, 32'h0,        32'h0};
        tbl[9] = '{1'b0, 16'h0001, 32'h0,        32'hCAFE0001};

        rst_n = 1'b0; mem_sel = 1'b0; mem_w = 1'b0; addr_bus = '0;
        tb_en = 1'b1; tb_dat = SENT;
        repeat (3) @(negedge clk);
        #1;
        chk("reset ready", 32'(mem_ready), 32'h0);
        chk("reset bus", data_bus, SENT);
        chk_status("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, 1'b0);

        // mem_sel held high: a read is re-captured every LAT+3 cycles
        mem_sel = 1'b1; mem_w = 1'b0; addr_bus = 16'h0001; tb_en = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 15) mem_sel = 1'b0;
            #1;
            chk($sformatf("b2b ready k=%0d", k), 32'(mem_ready), 32'((k % 5) == 3));
            if ((k % 5) == 3 || (k % 5) == 4)
                chk($sformatf("b2b rdata k=%0d", k), data_bus, 32'hCAFE0001);
        end
        m_rd += 3;
        chk_status("b2b");

        // A reset asserted in WAIT aborts the pending write.
        tb_en = 1'b1;
        mem_sel = 1'b1; mem_w = 1'b1; addr_bus = 16'h0020; tb_dat = 32'h00005555;
        @(negedge clk);
        mem_sel = 1'b0; tb_dat = SENT; rst_n = 1'b0;
        #1;
        m_rd = 0; m_wr = 0; m_err = 1'b0;
        chk("rst ready", 32'(mem_ready), 32'h0);
        chk("rst bus", data_bus, SENT);
        chk_status("rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rst hold ready", 32'(mem_ready), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_txn("post-rst read", 1'b0, 16'h0020, 32'h0, 32'h11110000, 1'b0);

        // Seventeen writes drive the 4-bit write counter into saturation.
        for (int i = 0; i < 17; i++)
            do_txn("sat wr", 1'b1, 16'h0002, 32'(i), 32'h0, 1'b0);
        chk("sat wr_count", 32'(wr_count), 32'hF);

        // Random traffic, using fully preloaded in-range addresses.
        for (int i = 0; i < 8; i++)
            do_txn("preload", 1'b1, 16'(i), $urandom, 32'h0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            int r;
            int gap;
            r = $urandom_range(0, 9);
            if (r < 8)       a = 16'(r);
            else if (r == 8) a = 16'h0FFF;
            else             a = 16'($urandom_range(4096, 65535));
            w = 1'($urandom);
            d = $urandom;
            e = (a >= 16'd4096) ? 32'h0 : model_mem[int'(a)];
            do_txn("rand", w, a, d, e, 1'b1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                tb_en = 1'b1; tb_dat = SENT;
                #1;
                chk("idle ready", 32'(mem_ready), 32'h0);
                chk("idle bus", data_bus, SENT);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
